// File: rtl/runway_pkg.sv
// Shared types and lamp-pattern helpers for the runway approach-light sequencer.
package runway_pkg;

  typedef enum logic [1:0] {
    CALM    = 2'b00,
    SWEEP_L = 2'b01,
    SWEEP_R = 2'b10,
    FLASH   = 2'b11
  } mode_e;

  // CALM lights the symmetric pair (k, n-1-k); they coincide at the centre for odd n.
  function automatic logic calm_lamp(input int k, input int lamp, input int n);
    return (lamp == k) || (lamp == n - 1 - k);
  endfunction

  // State of one lamp in the first frame of a mode, for an n-lamp runway.
  function automatic logic start_pattern(input mode_e m, input int lamp, input int n);
    logic on;
    on = 1'b0;
    case (m)
      CALM:    on = calm_lamp(0, lamp, n);
      SWEEP_L: on = (lamp == 0);
      SWEEP_R: on = (lamp == n - 1);
      FLASH:   on = (lamp < n);
    endcase
    return on;
  endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Free-running divider: one-cycle tick every TICK_DIV clocks, counting 0..TICK_DIV-1.
module tick_prescaler #(
  parameter int TICK_DIV = 25_000_000
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);

  localparam int CW = $clog2(TICK_DIV + 1);
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // Pure decode of the count register, so it is high on every cycle when TICK_DIV=1.
  assign tick = (cnt_q == LAST);

  always_comb begin
    cnt_d = tick ? '0 : cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/runway_pattern_gen.sv
// Runway approach-light sequencer: four lamp patterns stepped once per prescaler tick,
// with hold, and mode changes taking effect on the next tick.
module runway_pattern_gen
  import runway_pkg::*;
#(
  parameter int NUM_LIGHTS = 3,
  parameter int TICK_DIV   = 25_000_000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [1:0]            mode,
  input  logic                  hold,
  output logic [NUM_LIGHTS-1:0] lights,
  output logic                  tick,
  output logic [1:0]            mode_active
);

  localparam int HALF = (NUM_LIGHTS + 1) / 2;
  localparam int KW   = $clog2(HALF + 1);

  logic [NUM_LIGHTS-1:0] lights_q, lights_d;
  logic [KW-1:0]         k_q, k_d;
  mode_e                 mode_active_q, mode_active_d;
  logic                  primed_q, primed_d;
  mode_e                 mode_req;
  logic                  tick_w;

  tick_prescaler #(
    .TICK_DIV(TICK_DIV)
  ) u_prescaler (
    .clk  (clk),
    .reset(reset),
    .tick (tick_w)
  );

  always_comb begin
    mode_req      = mode_e'(mode);
    lights_d      = lights_q;
    k_d           = k_q;
    mode_active_d = mode_active_q;
    primed_d      = primed_q;
    if (tick_w) begin
      // A new mode restarts its pattern even while held.
      if (!primed_q || (mode_req != mode_active_q)) begin
        for (int i = 0; i < NUM_LIGHTS; i++) begin
          lights_d[i] = start_pattern(mode_req, i, NUM_LIGHTS);
        end
        k_d           = '0;
        mode_active_d = mode_req;
        primed_d      = 1'b1;
      end else if (!hold) begin
        case (mode_active_q)
          CALM: begin
            k_d = (k_q == KW'(HALF - 1)) ? '0 : k_q + 1'b1;
            for (int i = 0; i < NUM_LIGHTS; i++) begin
              lights_d[i] = calm_lamp(int'(k_d), i, NUM_LIGHTS);
            end
          end
          SWEEP_L: lights_d = {lights_q[NUM_LIGHTS-2:0], lights_q[NUM_LIGHTS-1]};
          SWEEP_R: lights_d = {lights_q[0], lights_q[NUM_LIGHTS-1:1]};
          FLASH:   lights_d = ~lights_q;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      lights_q      <= '0;
      k_q           <= '0;
      mode_active_q <= CALM;
      primed_q      <= 1'b0;
    end else begin
      lights_q      <= lights_d;
      k_q           <= k_d;
      mode_active_q <= mode_active_d;
      primed_q      <= primed_d;
    end
  end

  assign lights      = lights_q;
  assign tick        = tick_w;
  assign mode_active = mode_active_q;

endmodule

// File: tb/tb_runway_pattern_gen.sv
// Directed bench for runway_pattern_gen: 5 lamps / divide-by-4, plus 3- and 2-lamp
// instances at divide-by-1.
module tb_runway_pattern_gen;

  logic       clk;
  logic       reset;
  logic [1:0] mode;
  logic       hold;
  logic [4:0] lights_a;
  logic       tick_a;
  logic [1:0] mode_active_a;

  logic       reset_b;
  logic [1:0] mode_b;
  logic       hold_b;
  logic [2:0] lights_b;
  logic       tick_b;
  logic [1:0] mode_active_b;
  logic [1:0] lights_c;
  logic       tick_c;
  logic [1:0] mode_active_c;

  int checks;
  int failures;

  runway_pattern_gen #(.NUM_LIGHTS(5), .TICK_DIV(4)) dut_a (
    .clk(clk), .reset(reset), .mode(mode), .hold(hold),
    .lights(lights_a), .tick(tick_a), .mode_active(mode_active_a)
  );

  runway_pattern_gen #(.NUM_LIGHTS(3), .TICK_DIV(1)) dut_b (
    .clk(clk), .reset(reset_b), .mode(mode_b), .hold(hold_b),
    .lights(lights_b), .tick(tick_b), .mode_active(mode_active_b)
  );

  runway_pattern_gen #(.NUM_LIGHTS(2), .TICK_DIV(1)) dut_c (
    .clk(clk), .reset(reset_b), .mode(mode_b), .hold(hold_b),
    .lights(lights_c), .tick(tick_c), .mode_active(mode_active_c)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %b expected %b", tag, obs[7:0], exp[7:0]);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Leaves the bench on the negedge where reset has just been released (cnt=0).
  task automatic do_reset();
    reset = 1'b1;
    cyc(2);
    reset = 1'b0;
  endtask

  logic [4:0] sl_seq [5];
  logic [4:0] sr_seq [5];

  initial begin
    checks   = 0;
    failures = 0;
    reset    = 1'b1;
    mode     = 2'b00;
    hold     = 1'b0;
    reset_b  = 1'b1;
    mode_b   = 2'b00;
    hold_b   = 1'b0;
    sl_seq   = '{5'b00010, 5'b00100, 5'b01000, 5'b10000, 5'b00001};
    sr_seq   = '{5'b01000, 5'b00100, 5'b00010, 5'b00001, 5'b10000};

    // CALM from reset: dark for four cycles, tick on the fourth
    do_reset();
    check_val("rst_lights", 32'(lights_a), 32'b00000);
    check_val("rst_tick", 32'(tick_a), 32'd0);
    check_val("rst_mode_active", 32'(mode_active_a), 32'd0);
    for (int i = 1; i <= 3; i++) begin
      cyc(1);
      check_val("t1_dark", 32'(lights_a), 32'b00000);
      check_val("t1_tick", 32'(tick_a), (i == 3) ? 32'd1 : 32'd0);
    end
    cyc(1);
    check_val("t1_calm0", 32'(lights_a), 32'b10001);
    check_val("t1_tick_low", 32'(tick_a), 32'd0);
    cyc(4);
    check_val("t1_calm1", 32'(lights_a), 32'b01010);
    cyc(4);
    check_val("t1_calm2", 32'(lights_a), 32'b00100);
    cyc(4);
    check_val("t1_calm_wrap", 32'(lights_a), 32'b10001);

    // Mode glitches between ticks; only the tick-cycle value matters
    cyc(4);
    check_val("t3_calm_at_01010", 32'(lights_a), 32'b01010);
    cyc(1); mode = 2'b11;
    cyc(1); mode = 2'b00;
    cyc(1); mode = 2'b11;
    cyc(1);
    check_val("t3_flash_on", 32'(lights_a), 32'b11111);
    check_val("t3_mode_active", 32'(mode_active_a), 32'd3);
    cyc(4);
    check_val("t3_flash_off", 32'(lights_a), 32'b00000);
    cyc(4);
    check_val("t3_flash_on2", 32'(lights_a), 32'b11111);
    cyc(1); mode = 2'b01;
    cyc(1); mode = 2'b11;
    cyc(2);
    check_val("t3_glitch_ignored", 32'(lights_a), 32'b00000);
    check_val("t3_glitch_mode", 32'(mode_active_a), 32'd3);

    // SWEEP_L from reset
    mode = 2'b01;
    do_reset();
    cyc(4);
    check_val("t2_sl_start", 32'(lights_a), 32'b00001);
    check_val("t2_sl_mode", 32'(mode_active_a), 32'd1);
    for (int i = 0; i < 5; i++) begin
      cyc(4);
      check_val("t2_sl_step", 32'(lights_a), 32'(sl_seq[i]));
    end
    cyc(4);
    check_val("t4_pre1", 32'(lights_a), 32'b00010);
    cyc(4);
    check_val("t4_pre2", 32'(lights_a), 32'b00100);

    // Hold freezes the pattern while tick keeps running; a mode change overrides it
    hold = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc(3);
      check_val("t4_hold_tick", 32'(tick_a), 32'd1);
      cyc(1);
      check_val("t4_hold_lights", 32'(lights_a), 32'b00100);
    end
    mode = 2'b10;
    cyc(4);
    check_val("t4_sr_under_hold", 32'(lights_a), 32'b10000);
    check_val("t4_sr_mode", 32'(mode_active_a), 32'd2);
    cyc(4);
    check_val("t4_still_held", 32'(lights_a), 32'b10000);
    hold = 1'b0;
    cyc(4);
    check_val("t4_released", 32'(lights_a), 32'b01000);

    // Reset pulse at cnt=2 mid-sweep
    cyc(2);
    reset = 1'b1;
    cyc(1);
    reset = 1'b0;
    check_val("t5_lights", 32'(lights_a), 32'b00000);
    check_val("t5_mode_active", 32'(mode_active_a), 32'd0);
    check_val("t5_tick", 32'(tick_a), 32'd0);
    for (int i = 1; i <= 3; i++) begin
      cyc(1);
      check_val("t5_dark", 32'(lights_a), 32'b00000);
      check_val("t5_tick_seq", 32'(tick_a), (i == 3) ? 32'd1 : 32'd0);
    end
    cyc(1);
    check_val("t5_sr_start", 32'(lights_a), 32'b10000);
    check_val("t5_sr_mode", 32'(mode_active_a), 32'd2);
    for (int i = 0; i < 5; i++) begin
      cyc(4);
      check_val("t2_sr_step", 32'(lights_a), 32'(sr_seq[i]));
    end

    // Narrow instances at divide-by-1
    reset_b = 1'b0;
    check_val("t6_b_dark", 32'(lights_b), 32'b000);
    check_val("t6_b_tick", 32'(tick_b), 32'd1);
    check_val("t6_c_dark", 32'(lights_c), 32'b00);
    for (int i = 0; i < 4; i++) begin
      cyc(1);
      check_val("t6_b_calm", 32'(lights_b), (i % 2 == 0) ? 32'b101 : 32'b010);
      check_val("t6_c_calm", 32'(lights_c), 32'b11);
    end
    check_val("t6_b_mode", 32'(mode_active_b), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
